// File: rtl/demux_scheduler_pkg.sv
// Shared definitions for the demux scheduler: channel count, channel
// encodings, FSM state encoding and the round-robin slot picker.
package demux_scheduler_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // First free slot scanning ptr, ptr+1, ... (mod 4); falls back to ptr
    // when every slot is occupied so the select lines stay well defined.
    function automatic logic [1:0] rr_pick(input logic [NUM_CH-1:0] free,
                                           input logic [1:0]        ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr + 2'(i);
            if (!found && free[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/demux_scheduler_slot.sv
// One-entry output buffer for a single demux channel.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   load        - capture data_in this cycle (wins over a same-cycle drain)
//   data_in     - payload to capture
//   ready       - downstream consumer takes the held item
//   valid       - slot holds an item
//   data_out    - held payload, stable until consumed
module demux_scheduler_slot
    import demux_scheduler_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            data_out <= data_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_scheduler.sv
// Steers one valid/ready input stream into four single-entry channel
// buffers, either by explicit destination or round-robin over free slots,
// and drives the 2-bit demux select {s1,s2} for the datapath.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   in_valid/in_ready  - producer handshake; in_data payload, in_dest target
//   rr_mode            - 1 = round-robin, 0 = addressed
//   s1, s2             - demux select = current target {MSB, LSB}
//   out_valid/out_ready- per-channel handshake, bit0 = channel A
//   out_data           - per-channel payload, ch k at [k*DATA_W +: DATA_W]
//   xfer_count         - accepted input items, wraps
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal operation, input accepted into the target slot
// ST_DRAIN | mode change pending; input blocked until every slot empties
module demux_scheduler
    import demux_scheduler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [1:0]               in_dest,
    input  logic                     rr_mode,
    output logic                     s1,
    output logic                     s2,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         xfer_count
);

    state_e              state_q, state_d;
    logic                mode_q;
    logic [1:0]          rr_ptr;
    logic [1:0]          target;
    logic [NUM_CH-1:0]   slot_free;
    logic                accept;
    logic                drain_done;

    // A slot draining this cycle can be refilled in the same cycle.
    assign slot_free = ~out_valid | out_ready;

    // The latched mode drives target selection; a pending mode change only
    // takes effect once the scheduler has drained.
    assign target = mode_q ? rr_pick(slot_free, rr_ptr) : in_dest;
    assign s1     = target[1];
    assign s2     = target[0];

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (rr_mode != mode_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    in_ready = slot_free[target];
                end
            end
            ST_DRAIN: begin
                if (out_valid == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign accept     = in_valid && in_ready;
    assign drain_done = (state_q == ST_DRAIN) && (out_valid == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= rr_mode;
            rr_ptr     <= CH_A;
            xfer_count <= '0;
        end else begin
            if (accept) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
            // drain_done and accept are exclusive: in_ready is low in DRAIN.
            if (drain_done) begin
                mode_q <= rr_mode;
                rr_ptr <= CH_A;
            end else if (accept && mode_q) begin
                rr_ptr <= target + 2'd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_scheduler_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (accept && (target == 2'(k))),
            .data_in  (in_data),
            .ready    (out_ready[k]),
            .valid    (out_valid[k]),
            .data_out (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_demux_scheduler.sv
module tb_demux_scheduler;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_dest;
    logic        rr_mode;
    logic        s1, s2;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [15:0] xfer_count;

    demux_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .rr_mode    (rr_mode),
        .s1         (s1),
        .s2         (s2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Reference model: four buffered items, a scan pointer, a counter and
    // a "waiting for empty" flag for mode changes.
    logic [3:0]  m_valid;
    logic [7:0]  m_data [4];
    logic [1:0]  m_ptr;
    logic [15:0] m_cnt;
    logic        m_mode;
    logic        m_drain;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expected);
        n_total++;
        assert (obs === expected) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expected);
    endtask

    function automatic logic [1:0] exp_target();
        logic [3:0] fr;
        fr = ~m_valid | out_ready;
        if (!m_mode) return in_dest;
        for (int i = 0; i < 4; i++)
            if (fr[(m_ptr + i) % 4]) return 2'((m_ptr + i) % 4);
        return m_ptr;
    endfunction

    task automatic model_reset();
        m_valid = '0;
        for (int k = 0; k < 4; k++) m_data[k] = '0;
        m_ptr   = '0;
        m_cnt   = '0;
        m_mode  = rr_mode;
        m_drain = 1'b0;
    endtask

    // One clock: check combinational outputs before the edge, advance the
    // model with the sampled inputs, check registered outputs after it.
    task automatic cycle();
        logic [1:0]  tgt;
        logic [3:0]  fr;
        logic        rdy, acc;
        logic [31:0] exp_data;
        #1;
        fr  = ~m_valid | out_ready;
        tgt = exp_target();
        rdy = !m_drain && (rr_mode == m_mode) && fr[tgt];
        chk("select", {s1, s2}, tgt);
        chk("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (m_drain) begin
                if (m_valid == 4'b0) begin
                    m_drain = 1'b0;
                    m_mode  = rr_mode;
                    m_ptr   = 2'd0;
                end
            end else if (rr_mode != m_mode) begin
                m_drain = 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                if (acc && tgt == 2'(k)) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = in_data;
                end else if (m_valid[k] && out_ready[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            if (acc) begin
                m_cnt = m_cnt + 16'd1;
                if (m_mode) m_ptr = tgt + 2'd1;
            end
        end
        #1;
        for (int k = 0; k < 4; k++) exp_data[k*8 +: 8] = m_data[k];
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, exp_data);
        chk("xfer_count", xfer_count, m_cnt);
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [7:0] data, input logic [3:0] ordy);
        in_valid  = v;
        in_dest   = d;
        in_data   = data;
        out_ready = ordy;
        cycle();
    endtask

    initial begin
        logic got;
        int   guard;
        int   t2_ch [6];
        int   t3_ch [3];
        t3_ch = '{2, 3, 0};

        reset = 1'b1; rr_mode = 1'b0; in_valid = 1'b0; in_data = '0;
        in_dest = '0; out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        chk("rst_valid", out_valid, 4'h0);
        chk("rst_count", xfer_count, 16'h0);
        reset = 1'b0;

        // 1: addressed, dest 0..3
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'h11 + 8'(i), 4'hF);
            chk("t1_lane", out_data[i*8 +: 8], 8'h11 + 8'(i));
            chk("t1_valid", out_valid[i], 1'b1);
        end
        chk("t1_count", xfer_count, 16'd4);

        // 2: round-robin, six back-to-back items
        rr_mode = 1'b1;
        repeat (3) drive(1'b0, 2'd0, 8'h00, 4'hF);
        for (int i = 0; i < 6; i++) begin
            t2_ch[i] = i % 4;
            drive(1'b1, 2'd0, 8'h21 + 8'(i), 4'hF);
            chk("t2_order", out_valid, 4'b0001 << t2_ch[i]);
        end

        // 3: round-robin with B stalled and full
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 8'hC0 + 8'(i), 4'b1101);
            chk("t3_target", out_valid[t3_ch[i]], 1'b1);
            chk("t3_b_hold", {out_valid[1], out_data[15:8]}, {1'b1, 8'h26});
        end

        // 4: addressed, stall on full C then drain-and-refill
        rr_mode = 1'b0;
        repeat (3) drive(1'b0, 2'd0, 8'h00, 4'hF);
        drive(1'b1, 2'd2, 8'h41, 4'b1011);
        in_data = 8'h42;
        #1 chk("t4_stall", in_ready, 1'b0);
        cycle();
        chk("t4_hold", out_data[23:16], 8'h41);
        in_data = 8'h43; out_ready = 4'hF;
        #1 chk("t4_refill_rdy", in_ready, 1'b1);
        cycle();
        chk("t4_refill", {out_valid[2], out_data[23:16]}, {1'b1, 8'h43});

        // 5: mode toggle with A and C full
        drive(1'b1, 2'd0, 8'h51, 4'h0);
        rr_mode = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t5_blocked", in_ready, 1'b0);
            cycle();
        end
        out_ready = 4'hF;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1 got = in_ready;
            cycle();
        end
        chk("t5_accepted", got, 1'b1);
        chk("t5_to_a", {out_valid, out_data[7:0]}, {4'b0001, 8'h55});
        in_valid = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) rr_mode = ~rr_mode;
            drive(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
        end
        reset = 1'b0;

        // 6: counter wrap and reset with buffered items
        rr_mode = 1'b1;
        repeat (4) drive(1'b0, 2'd0, 8'h00, 4'hF);
        guard = 0;
        while (m_cnt != 16'hFFFC && guard < 70000) begin
            drive(1'b1, 2'd0, 8'(guard), 4'hF);
            guard++;
        end
        chk("t6_reach", m_cnt, 16'hFFFC);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        repeat (3) drive(1'b1, 2'd0, 8'hA5, 4'h0);
        chk("t6_ffff", xfer_count, 16'hFFFF);
        chk("t6_three_full", $countones(out_valid), 3);
        drive(1'b1, 2'd0, 8'hA6, 4'h0);
        chk("t6_wrap", xfer_count, 16'h0000);
        drive(1'b1, 2'd0, 8'hA7, 4'b0001);
        chk("t6_after_wrap", {out_valid, xfer_count}, {4'hF, 16'h0001});
        reset = 1'b1;
        drive(1'b1, 2'd0, 8'hA8, 4'h0);
        chk("t6_rst_valid", out_valid, 4'h0);
        chk("t6_rst_count", xfer_count, 16'h0);
        reset = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
